// File: rtl/rayleigh_multi_eig.sv
// Rayleigh-quotient eigenvalue estimates v_k^T A v_k for NUM_VEC vectors on one double MAC.
// Optional build macro RAYLEIGH_NORMALISE_EN divides each estimate by v_k^T v_k.
package fp_double;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    function automatic logic is_nan(input logic [63:0] a);
        return (&a[62:52]) && (|a[51:0]);
    endfunction
    function automatic logic is_inf(input logic [63:0] a);
        return (&a[62:52]) && !(|a[51:0]);
    endfunction
    function automatic logic is_zero(input logic [63:0] a);
        return !(|a[62:0]);
    endfunction
    // value = sig(a) * 2^xp(a), covering subnormals
    function automatic logic [52:0] sig(input logic [63:0] a);
        return {a[62:52] != 11'd0, a[51:0]};
    endfunction
    function automatic int xp(input logic [63:0] a);
        return (a[62:52] == 11'd0) ? -1074 : int'(a[62:52]) - 1075;
    endfunction

    // Round-to-nearest-even of (-1)^s * m * 2^e into a double.
    function automatic logic [63:0] pack(input logic s, input logic [127:0] m, input int e);
        int p, tgt, sh, ex;
        logic [53:0] q;
        logic [127:0] rem;
        logic g, st;
        if (m == '0) return {s, 63'd0};
        p = 0;
        for (int i = 0; i < 128; i++) if (m[i]) p = i;
        tgt = (p + e - 52 > -1074) ? p + e - 52 : -1074;
        sh = tgt - e;
        g = 1'b0;
        st = 1'b0;
        if (sh <= 0) q = 54'(m << (-sh));
        else if (sh > 128) begin
            q = '0;
            st = 1'b1;
        end else begin
            q = 54'(m >> sh);
            rem = m << (128 - sh);
            g = rem[127];
            st = |rem[126:0];
        end
        if (g && (st || q[0])) q = q + 54'd1;
        if (q[53]) begin
            q = q >> 1;
            tgt = tgt + 1;
        end
        ex = q[52] ? tgt + 1075 : 0;
        if (ex >= 2047) return {s, 11'h7FF, 52'd0};
        return {s, 11'(ex), q[51:0]};
    endfunction

    function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ma, mb;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)))
            return QNAN;
        if (is_inf(a) || is_inf(b)) return {a[63] ^ b[63], 11'h7FF, 52'd0};
        ma = 128'(sig(a));
        mb = 128'(sig(b));
        return pack(a[63] ^ b[63], ma * mb, xp(a) + xp(b));
    endfunction

    // Larger operand sits 64 bits up; a far-smaller operand collapses into a sticky LSB.
    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x, y;
        logic [127:0] mx, my, ys, r;
        int d;
        logic sr;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[63] != b[63]))) return QNAN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        if (xp(a) >= xp(b)) begin x = a; y = b; end
        else begin x = b; y = a; end
        d  = xp(x) - xp(y);
        mx = 128'(sig(x)) << 64;
        ys = 128'(sig(y));
        if (d <= 64) my = ys << (64 - d);
        else if (d >= 128) my = {127'd0, |ys};
        else my = (ys >> (d - 64)) | {127'd0, |(ys << (192 - d))};
        if (x[63] == y[63]) begin
            r = mx + my;
            sr = x[63];
        end else if (mx >= my) begin
            r = mx - my;
            sr = (r == '0) ? 1'b0 : x[63];
        end else begin
            r = my - mx;
            sr = y[63];
        end
        return pack(sr, r, xp(x) - 64);
    endfunction

`ifdef RAYLEIGH_NORMALISE_EN
    function automatic logic [63:0] fp_div(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] na, nb, q;
        int ea, eb;
        if (is_nan(a) || is_nan(b) || (is_zero(a) && is_zero(b)) || (is_inf(a) && is_inf(b)))
            return QNAN;
        if (is_inf(a) || is_zero(b)) return {a[63] ^ b[63], 11'h7FF, 52'd0};
        if (is_inf(b) || is_zero(a)) return {a[63] ^ b[63], 63'd0};
        na = 128'(sig(a)); ea = xp(a);
        nb = 128'(sig(b)); eb = xp(b);
        for (int i = 0; i < 52; i++) begin
            if (!na[52]) begin na = na << 1; ea = ea - 1; end
            if (!nb[52]) begin nb = nb << 1; eb = eb - 1; end
        end
        na = na << 64;
        q = na / nb;
        if ((na % nb) != '0) q = q | 128'd1;
        return pack(a[63] ^ b[63], q, ea - eb - 64);
    endfunction
`endif
endpackage

module rayleigh_multi_eig #(
    parameter int SIZE_N  = 8,
    parameter int NUM_VEC = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [SIZE_N-1:0][SIZE_N-1:0][63:0]  timed_matrix,
    input  logic [NUM_VEC-1:0][SIZE_N-1:0][63:0] vectors,
    output logic [NUM_VEC-1:0][63:0]             eigenvalue,
    output logic [NUM_VEC-1:0]                   valid,
    output logic                                 busy,
`ifdef RAYLEIGH_NORMALISE_EN
    output logic                                 div_zero,
`endif
    output logic                                 f
);
    import fp_double::*;

    localparam int IW = $clog2(SIZE_N);
    localparam int KW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(SIZE_N - 1);
    localparam logic [KW-1:0] LAST_K = KW'(NUM_VEC - 1);

`ifdef RAYLEIGH_NORMALISE_EN
    typedef enum logic [2:0] {IDLE, ROW, DOT, NORM_DIV, STORE, DONE} state_t;
    logic [63:0] sacc, ssum, quot;
    logic        div_go, div_f;
`else
    typedef enum logic [2:0] {IDLE, ROW, DOT, STORE, DONE} state_t;
`endif

    state_t                              state;
    logic [SIZE_N-1:0][SIZE_N-1:0][63:0] mat;
    logic [NUM_VEC-1:0][SIZE_N-1:0][63:0] vec;
    logic [SIZE_N-1:0][63:0]             w;
    logic [IW-1:0]                       ci, cj;
    logic [KW-1:0]                       k;
    logic [63:0]                         acc, sum, op_a, op_b;
    logic                                first;

    // ROW walks i (inner) then j (outer); DOT reuses j as the vector index.
    always_comb begin
        op_a  = vec[k][ci];
        op_b  = mat[ci][cj];
        first = (ci == '0);
        if (state == DOT) begin
            op_a  = w[cj];
            op_b  = vec[k][cj];
            first = (cj == '0);
        end
    end

    assign sum = fp_add(first ? 64'd0 : acc, fp_mul(op_a, op_b));
`ifdef RAYLEIGH_NORMALISE_EN
    assign ssum = fp_add(first ? 64'd0 : sacc, fp_mul(vec[k][cj], vec[k][cj]));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            f          <= 1'b0;
            valid      <= '0;
            eigenvalue <= '0;
            ci         <= '0;
            cj         <= '0;
            k          <= '0;
            acc        <= '0;
`ifdef RAYLEIGH_NORMALISE_EN
            sacc       <= '0;
            quot       <= '0;
            div_go     <= 1'b0;
            div_f      <= 1'b0;
            div_zero   <= 1'b0;
`endif
        end else begin
            f <= (state == DONE);
            case (state)
                IDLE: if (start) begin
                    mat   <= timed_matrix;
                    vec   <= vectors;
                    valid <= '0;
                    busy  <= 1'b1;
                    ci    <= '0;
                    cj    <= '0;
                    k     <= '0;
`ifdef RAYLEIGH_NORMALISE_EN
                    div_zero <= 1'b0;
`endif
                    state <= ROW;
                end
                ROW: begin
                    acc <= sum;
                    if (ci == LAST_I) begin
                        w[cj] <= sum;
                        ci    <= '0;
                        if (cj == LAST_I) begin
                            cj    <= '0;
                            state <= DOT;
                        end else cj <= cj + 1'b1;
                    end else ci <= ci + 1'b1;
                end
                DOT: begin
                    acc <= sum;
`ifdef RAYLEIGH_NORMALISE_EN
                    sacc <= ssum;
`endif
                    if (cj == LAST_I) begin
                        cj <= '0;
`ifdef RAYLEIGH_NORMALISE_EN
                        div_go <= 1'b1;
                        state  <= NORM_DIV;
`else
                        state  <= STORE;
`endif
                    end else cj <= cj + 1'b1;
                end
`ifdef RAYLEIGH_NORMALISE_EN
                NORM_DIV: begin
                    div_go <= 1'b0;
                    if (div_go) begin
                        quot  <= fp_div(acc, sacc);
                        div_f <= 1'b1;
                    end
                    if (div_f) begin
                        div_f <= 1'b0;
                        state <= STORE;
                    end
                end
`endif
                STORE: begin
`ifdef RAYLEIGH_NORMALISE_EN
                    eigenvalue[k] <= is_zero(sacc) ? 64'd0 : quot;
                    if (is_zero(sacc)) div_zero <= 1'b1;
`else
                    eigenvalue[k] <= acc;
`endif
                    valid[k] <= 1'b1;
                    if (k == LAST_K) begin
                        k     <= '0;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= ROW;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rayleigh_multi_eig.sv
// Directed bench for rayleigh_multi_eig: latency, values, ignored restarts, reset abort, back-to-back.
`timescale 1ns/1ps
module tb_rayleigh_multi_eig;
    localparam int N = 8;
`ifdef RAYLEIGH_NORMALISE_EN
    localparam int TV = N*N + N + 1 + 2;
`else
    localparam int TV = N*N + N + 1;
`endif
    localparam logic [63:0] D1  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D2  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D3  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D4  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] D6  = 64'h4018_0000_0000_0000;
    localparam logic [63:0] D8  = 64'h4020_0000_0000_0000;
    localparam logic [63:0] D64 = 64'h4050_0000_0000_0000;
`ifdef RAYLEIGH_NORMALISE_EN
    localparam logic [63:0] E_ONES = D8;
    localparam logic [63:0] E_2E0  = D1;
`else
    localparam logic [63:0] E_ONES = D64;
    localparam logic [63:0] E_2E0  = D4;
`endif

    logic clk = 1'b0;
    logic rst, start4, start1;
    logic [N-1:0][N-1:0][63:0] mat;
    logic [3:0][N-1:0][63:0]   vec4;
    logic [0:0][N-1:0][63:0]   vec1;
    logic [3:0][63:0]          ev4;
    logic [0:0][63:0]          ev1;
    logic [3:0]                valid4;
    logic [0:0]                valid1;
    logic                      busy4, busy1, f4, f1;
`ifdef RAYLEIGH_NORMALISE_EN
    logic                      dz4, dz1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int tv[4];
    int tf, fcnt;
    logic busy_done, busy_f;

    always #5 clk = ~clk;

    rayleigh_multi_eig #(.SIZE_N(N), .NUM_VEC(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .timed_matrix(mat), .vectors(vec4),
        .eigenvalue(ev4), .valid(valid4), .busy(busy4),
`ifdef RAYLEIGH_NORMALISE_EN
        .div_zero(dz4),
`endif
        .f(f4));

    rayleigh_multi_eig #(.SIZE_N(N), .NUM_VEC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .timed_matrix(mat), .vectors(vec1),
        .eigenvalue(ev1), .valid(valid1), .busy(busy1),
`ifdef RAYLEIGH_NORMALISE_EN
        .div_zero(dz1),
`endif
        .f(f1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_diag();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = (i == j) ? $realtobits(real'(i + 1)) : 64'd0;
        vec4 = '0;
        vec4[0][2] = D1;
        vec4[1][5] = D1;
        vec4[2][7] = D1;
        vec4[3][0] = D2;
    endtask

    task automatic set_ones();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) mat[i][j] = D1;
            for (int q = 0; q < 4; q++) vec4[q][i] = D1;
        end
    endtask

    task automatic chk_diag(input string tag);
        chk({tag, "_ev0"}, ev4[0], D3);
        chk({tag, "_ev1"}, ev4[1], D6);
        chk({tag, "_ev2"}, ev4[2], D8);
        chk({tag, "_ev3"}, ev4[3], E_2E0);
    endtask

    // One accepted start on the 4-vector DUT; optionally re-pulses start with other data mid-run.
    task automatic run4(input int alt1, input int alt2);
        int n;
        logic [3:0] vp;
        tf = -1; fcnt = 0; busy_done = 1'b1; busy_f = 1'b1;
        for (int q = 0; q < 4; q++) tv[q] = -1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        vp = '0;
        while (n < 5*TV && !(tf >= 0 && n >= tf + 4)) begin
            if (n == alt1 || n == alt2) begin
                start4 = 1'b1;
                set_ones();
            end else start4 = 1'b0;
            @(posedge clk); #1;
            n++;
            for (int q = 0; q < 4; q++) if (valid4[q] && !vp[q]) tv[q] = n;
            if (valid4[3] && !vp[3]) busy_done = busy4;
            if (f4) begin
                fcnt++;
                if (tf < 0) begin tf = n; busy_f = busy4; end
            end
            vp = valid4;
        end
        start4 = 1'b0;
    endtask

    initial begin
        int n, t1, fa, fb;
        logic b_at_f, b_after;
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
        mat = '0; vec4 = '0; vec1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy4), 64'd0);
        chk("rst_f", 64'(f4), 64'd0);
        chk("rst_valid", 64'(valid4), 64'd0);
        chk("rst_ev", ev4[0] | ev4[1] | ev4[2] | ev4[3], 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single vector, identity matrix, v = e0
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mat[i][j] = (i == j) ? D1 : 64'd0;
        vec1 = '0;
        vec1[0][0] = D1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0; t1 = -1;
        while (n < 3*TV && t1 < 0) begin
            @(posedge clk); #1;
            n++;
            if (f1) t1 = n;
        end
        chk("nv1_f_cycle", 64'(t1), 64'(TV + 1));
        chk("nv1_ev", ev1[0], D1);
        chk("nv1_valid", 64'(valid1), 64'd1);
        chk("nv1_busy", 64'(busy1), 64'd0);
`ifdef RAYLEIGH_NORMALISE_EN
        chk("nv1_divzero", 64'(dz1), 64'd0);
`endif

        // diagonal matrix, four vectors: valid staircase and f timing
        set_diag();
        run4(-1, -1);
        for (int q = 0; q < 4; q++) chk("diag_valid_cycle", 64'(tv[q]), 64'(TV*(q + 1)));
        chk("diag_f_cycle", 64'(tf), 64'(4*TV + 1));
        chk("diag_f_pulses", 64'(fcnt), 64'd1);
        chk("diag_busy_done", 64'(busy_done), 64'd0);
        chk("diag_busy_f", 64'(busy_f), 64'd0);
        chk_diag("diag");

        // all-ones matrix and vectors
        set_ones();
        run4(-1, -1);
        for (int q = 0; q < 4; q++) chk("ones_ev", ev4[q], E_ONES);
`ifdef RAYLEIGH_NORMALISE_EN
        chk("ones_divzero", 64'(dz4), 64'd0);
`endif

        // start re-pulsed with other data at cycles 10 and 50 must be ignored
        set_diag();
        run4(10, 50);
        chk_diag("restart");
        chk("restart_f_pulses", 64'(fcnt), 64'd1);
        chk("restart_f_cycle", 64'(tf), 64'(4*TV + 1));

        // reset at cycle 100 aborts the run
        set_ones();
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("pre_rst_valid0", 64'(valid4[0]), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy4), 64'd0);
        chk("abort_valid", 64'(valid4), 64'd0);
        chk("abort_ev", ev4[0] | ev4[1] | ev4[2] | ev4[3], 64'd0);
        set_diag();
        run4(-1, -1);
        chk_diag("after_rst");
        chk("after_rst_f_cycle", 64'(tf), 64'(4*TV + 1));

        // start held high: one IDLE cycle between f and the next accept
        set_ones();
        start4 = 1'b1;
        @(posedge clk); #1;
        n = 0; fa = -1; fb = -1; b_at_f = 1'b1; b_after = 1'b0;
        while (n < 3*(4*TV + 2) && fb < 0) begin
            @(posedge clk); #1;
            n++;
            if (fa >= 0 && n == fa + 1) b_after = busy4;
            if (f4) begin
                if (fa < 0) begin
                    fa = n;
                    b_at_f = busy4;
                end else begin
                    fb = n;
                    start4 = 1'b0;
                end
            end
        end
        start4 = 1'b0;
        chk("b2b_f1_cycle", 64'(fa), 64'(4*TV + 1));
        chk("b2b_busy_at_f", 64'(b_at_f), 64'd0);
        chk("b2b_busy_after", 64'(b_after), 64'd1);
        chk("b2b_f2_cycle", 64'(fb), 64'(2*(4*TV + 1) + 1));
        chk("b2b_ev0", ev4[0], E_ONES);
        chk("b2b_ev3", ev4[3], E_ONES);
        repeat (3) @(posedge clk);

`ifdef RAYLEIGH_NORMALISE_EN
        // zero vectors: quotient forced to +0.0 and div_zero raised
        set_ones();
        vec4 = '0;
        run4(-1, -1);
        for (int q = 0; q < 4; q++) chk("dz_ev", ev4[q], 64'd0);
        chk("dz_flag", 64'(dz4), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
